execute_stage_md: RTL and testbench

Execute stage for the 5-stage RISC-V pipeline. It is the parametrised successor of the single-cycle execute stage and adds:
- an XLEN-wide ALU with shifts and compares;
- full funct3 branch resolution and JALR target generation;
- an iterative RV32M multiply/divide unit that stalls the pipeline through a busy handshake.

It sits between the ID/EX register and the EX/MEM register, which it contains. It takes forwarding selects from the hazard unit.

---
 rtl/exec_pkg.sv | 49 ++++
 rtl/execute_stage_md_md_unit.sv | 161 ++++++++++++++++
 rtl/execute_stage_md.sv | 164 ++++++++++++++++
 tb/tb_execute_stage_md.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute stage.
//   - ALU operation codes (4 bit)
//   - branch funct3 and M-extension funct3 constants
//   - forward-select encodings
//   - md_unit FSM state enum
package exec_pkg;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Branch funct3
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // M-extension funct3
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Forward selects (11 falls back to the register file value)
    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_RESW = 2'b01;
    localparam logic [1:0] FWD_ALUM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

endpackage

// File: rtl/execute_stage_md_md_unit.sv
// md_unit: iterative RV32M/RV64M multiply/divide.
//   Shift-add multiply and restoring divide on operand magnitudes, with a
//   sign fix-up applied to the final result. One iteration per cycle.
// Ports:
//   clk, resetn      clock, async active-low reset
//   start            M op present in E (ignored while flush is high)
//   flush            abandon / do not start
//   funct3           M-extension funct3, captured at start
//   opA, opB         post-forward operands, captured at start
//   busy             combinational stall request
//   done             result valid this cycle
//   result           selected result (valid when done)
module md_unit import exec_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    mdState_t state, stateNext;
    logic     load, step;

    logic [CW-1:0]   cnt;
    logic [2:0]      opF3;
    logic [XLEN-1:0] accHi;   // mul: product high half / div: partial remainder
    logic [XLEN-1:0] accLo;   // mul: multiplier, shifting into low half / div: dividend -> quotient
    logic [XLEN-1:0] opReg;   // mul: multiplicand magnitude / div: divisor magnitude
    logic            negRes;  // negate product or quotient
    logic            negRem;  // negate remainder (follows dividend sign)
    logic            divZero;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MD_IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && !flush) begin
                    busy      = 1'b1;
                    load      = 1'b1;
                    stateNext = MD_BUSY;
                end
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (flush) begin
                    stateNext = MD_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(1)) stateNext = MD_DONE;
                end
            end
            MD_DONE: stateNext = MD_IDLE;
            default: stateNext = MD_IDLE;
        endcase
    end

    assign done = (state == MD_DONE);

    // ---------------- operand conditioning ----------------
    logic            aSigned, bSigned, negA, negB, isDiv;
    logic [XLEN-1:0] magA, magB;

    always_comb begin
        isDiv = funct3[2];
        if (isDiv) begin
            aSigned = !funct3[0];
            bSigned = !funct3[0];
        end else begin
            aSigned = (funct3 != MD_MULHU);
            bSigned = (funct3 == MD_MUL) || (funct3 == MD_MULH);
        end
        negA = aSigned & opA[XLEN-1];
        negB = bSigned & opB[XLEN-1];
        magA = negA ? -opA : opA;
        magB = negB ? -opB : opB;
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]   mulSum;
    logic [XLEN:0]   divShift;
    logic            divGe;
    logic [XLEN:0]   divDiff;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opReg} : '0);
        divShift = {accHi, accLo[XLEN-1]};
        divGe    = (divShift >= {1'b0, opReg});
        divDiff  = divShift - {1'b0, opReg};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            opF3    <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opReg   <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
        end else if (load) begin
            cnt     <= CW'(XLEN);
            opF3    <= funct3;
            accHi   <= '0;
            accLo   <= isDiv ? magA : magB;
            opReg   <= isDiv ? magB : magA;
            negRes  <= negA ^ negB;
            negRem  <= negA;
            divZero <= (opB == '0);
        end else if (step) begin
            cnt <= cnt - CW'(1);
            if (opF3[2]) begin
                // Remainder never exceeds XLEN bits once the divisor is subtracted.
                accHi <= divGe ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
                accLo <= {accLo[XLEN-2:0], divGe};
            end else begin
                accHi <= mulSum[XLEN:1];
                accLo <= {mulSum[0], accLo[XLEN-1:1]};
            end
        end
    end

    // ---------------- result with sign fix-up ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod = {accHi, accLo};
        if (negRes) prod = -prod;
        // Divide by zero: quotient all ones regardless of sign; the remainder
        // falls out naturally as the dividend.
        quo = divZero ? '1 : (negRes ? -accLo : accLo);
        rem = negRem ? -accHi : accHi;
        case (opF3)
            MD_MUL:                  result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU,
            MD_MULHU:                result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:         result = quo;
            default:                 result = rem;
        endcase
    end

endmodule

// File: rtl/execute_stage_md.sv
// execute_stage_md: EX stage of the 5-stage RISC-V pipe, including EX/MEM.
//   Forwarding muxes, combinational ALU, branch/JALR resolution, and an
//   iterative M unit that stalls E via BusyE.
// Ports:
//   clk, resetn                       clock, async active-low reset
//   *E controls / operands            from ID/EX
//   ForwardAE/BE, ResultW, ALUResultM_fb  forwarding from the hazard unit
//   FlushE                            squash the instruction in E
//   PCTargetE, PCSrcE                 fetch redirect
//   BusyE                             stall request (M op in progress)
//   *M                                EX/MEM register outputs
module execute_stage_md import exec_pkg::*; #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC_PLUS4 = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      BranchOpE,
    input  logic            MdOpE,
    input  logic [2:0]      MdFunct3E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUResultM_fb,
    input  logic            FlushE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM
);

    localparam int SHW = $clog2(XLEN);

    // ---------------- forwarding ----------------
    function automatic logic [XLEN-1:0] fwd(input logic [XLEN-1:0] rf,
                                            input logic [1:0]      sel,
                                            input logic [XLEN-1:0] resW,
                                            input logic [XLEN-1:0] aluM);
        case (sel)
            FWD_RESW: fwd = resW;
            FWD_ALUM: fwd = aluM;
            default:  fwd = rf;
        endcase
    endfunction

    logic [XLEN-1:0] SrcA, SrcB, WriteDataE;

    assign SrcA       = fwd(RD1E, ForwardAE, ResultW, ALUResultM_fb);
    assign WriteDataE = fwd(RD2E, ForwardBE, ResultW, ALUResultM_fb);
    assign SrcB       = ALUSrcE ? ImmExtE : WriteDataE;

    // ---------------- ALU ----------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] aluResult;

    assign shamt = SrcB[SHW-1:0];

    always_comb begin
        case (ALUControlE)
            ALU_ADD:  aluResult = SrcA + SrcB;
            ALU_SUB:  aluResult = SrcA - SrcB;
            ALU_AND:  aluResult = SrcA & SrcB;
            ALU_OR:   aluResult = SrcA | SrcB;
            ALU_XOR:  aluResult = SrcA ^ SrcB;
            ALU_SLT:  aluResult = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: aluResult = {{(XLEN-1){1'b0}}, SrcA < SrcB};
            ALU_SLL:  aluResult = SrcA << shamt;
            ALU_SRL:  aluResult = SrcA >> shamt;
            ALU_SRA:  aluResult = XLEN'($signed(SrcA) >>> shamt);
            default:  aluResult = '0;
        endcase
    end

    // ---------------- branch / jump ----------------
    logic brEq, brLt, brLtu, taken;

    always_comb begin
        brEq  = (SrcA == WriteDataE);
        brLt  = ($signed(SrcA) < $signed(WriteDataE));
        brLtu = (SrcA < WriteDataE);
        case (BranchOpE)
            BR_BEQ:  taken = brEq;
            BR_BNE:  taken = !brEq;
            BR_BLT:  taken = brLt;
            BR_BGE:  taken = !brLt;
            BR_BLTU: taken = brLtu;
            BR_BGEU: taken = !brLtu;
            default: taken = 1'b0;
        endcase
    end

    assign PCTargetE = JalrE ? ((SrcA + ImmExtE) & ~XLEN'(1)) : (PCE + ImmExtE);
    assign PCSrcE    = !FlushE & (JumpE | JalrE | (BranchE & taken));

    // ---------------- multiply / divide ----------------
    logic            mdBusy, mdDone;
    logic [XLEN-1:0] mdResult;

    md_unit #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .resetn (resetn),
        .start  (MdOpE),
        .flush  (FlushE),
        .funct3 (MdFunct3E),
        .opA    (SrcA),
        .opB    (WriteDataE),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (mdResult)
    );

    // Gated so a held M op cannot raise a stall while reset is asserted.
    assign BusyE = mdBusy & resetn;

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= RESET_PC_PLUS4;
            RdM        <= '0;
        end else begin
            // Data fields load unconditionally; a bubble only kills the controls.
            ALUResultM <= mdDone ? mdResult : aluResult;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
            if (FlushE || BusyE) begin
                RegWriteM  <= 1'b0;
                MemWriteM  <= 1'b0;
                ResultSrcM <= '0;
                RdM        <= '0;
            end else begin
                RegWriteM  <= RegWriteE;
                MemWriteM  <= MemWriteE;
                ResultSrcM <= ResultSrcE;
                RdM        <= RdE;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed testbench for execute_stage_md (XLEN = 32).
module tb_execute_stage_md;
    import exec_pkg::*;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RST_PC4 = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            resetn;
    logic            RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      BranchOpE;
    logic            MdOpE;
    logic [2:0]      MdFunct3E;
    logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]      RdE;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [XLEN-1:0] ResultW, ALUResultM_fb;
    logic            FlushE;
    logic [XLEN-1:0] PCTargetE;
    logic            PCSrcE, BusyE, RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]      RdM;

    execute_stage_md #(.XLEN(XLEN), .RESET_PC_PLUS4(RST_PC4)) dut (
        .clk(clk), .resetn(resetn),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .BranchOpE(BranchOpE), .MdOpE(MdOpE),
        .MdFunct3E(MdFunct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .ALUResultM_fb(ALUResultM_fb), .FlushE(FlushE),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; JalrE = 0; BranchE = 0; ALUSrcE = 0;
        ResultSrcE = 0; ALUControlE = ALU_ADD; BranchOpE = 3'b010; MdOpE = 0; MdFunct3E = 0;
        ForwardAE = FWD_REG; ForwardBE = FWD_REG; FlushE = 0; RdE = 0;
    endtask

    // Runs one M op from IDLE; checks stall length, bubble and final result.
    task automatic runMd(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cycles;
        nop();
        MdOpE = 1; MdFunct3E = f3; RD1E = a; RD2E = b; RegWriteE = 1; RdE = 5'd9;
        #1;
        cycles = 0;
        while (BusyE === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
            if (cycles == 5) chk({tag, "_bubble_rw"}, RegWriteM, 0);
        end
        chk({tag, "_busy_cycles"}, cycles, 33);
        tick();
        chk({tag, "_result"}, ALUResultM, exp);
        chk({tag, "_rd"}, RdM, 9);
        nop();
    endtask

    logic [3:0]  aluOps [10] = '{ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL,
                                 ALU_SLL, ALU_AND, ALU_OR, ALU_XOR, 4'hF};
    logic [31:0] aluA   [10] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                 32'd1, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h1234};
    logic [31:0] aluB   [10] = '{32'd7, 32'd1, 32'd1, 32'd4, 32'd4,
                                 32'd33, 32'hFF00, 32'hFF00, 32'hFF00, 32'h5678};
    logic [31:0] aluExp [10] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h08000000,
                                 32'd2, 32'hF000, 32'hFFF0, 32'h0FF0, 32'd0};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nop();
        resetn = 0;
        RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0;
        ResultW = 0; ALUResultM_fb = 0;
        #12;
        chk("rst_regwrite", RegWriteM, 0);
        chk("rst_memwrite", MemWriteM, 0);
        chk("rst_aluresult", ALUResultM, 0);
        chk("rst_pcplus4", PCPlus4M, RST_PC4);
        chk("rst_busy", BusyE, 0);
        @(posedge clk); #1;
        resetn = 1;

        // 1. ADD with SrcA forwarded from M
        nop();
        ALUControlE = ALU_ADD; ForwardAE = FWD_ALUM; ALUResultM_fb = 5; RD1E = 99; RD2E = 7;
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b01; RdE = 5'd3; PCPlus4E = 32'h1004;
        #1;
        chk("add_busy", BusyE, 0);
        tick();
        chk("add_result", ALUResultM, 12);
        chk("add_regwrite", RegWriteM, 1);
        chk("add_memwrite", MemWriteM, 1);
        chk("add_resultsrc", ResultSrcM, 2'b01);
        chk("add_rd", RdM, 3);
        chk("add_pcplus4", PCPlus4M, 32'h1004);

        // Forward B from W, select 11 falls back to the register file
        nop();
        ForwardAE = 2'b11; ForwardBE = FWD_RESW; RD1E = 32'h100; ResultW = 32'h23; RD2E = 32'h999;
        tick();
        chk("fwd_w_sum", ALUResultM, 32'h123);
        chk("fwd_w_wdata", WriteDataM, 32'h23);

        // ALU table; odd entries take B from the immediate
        for (int i = 0; i < 10; i++) begin
            nop();
            ALUControlE = aluOps[i]; RD1E = aluA[i];
            if (i % 2 == 1) begin ALUSrcE = 1; ImmExtE = aluB[i]; RD2E = 32'hDEAD; end
            else            begin RD2E = aluB[i]; end
            tick();
            chk($sformatf("alu_op%0d", aluOps[i]), ALUResultM, aluExp[i]);
        end

        // 2. Branches
        nop();
        RD1E = 32'hFFFFFFFF; RD2E = 1; PCE = 32'h1000; ImmExtE = 32'h20; BranchE = 1;
        BranchOpE = BR_BLTU; #1;
        chk("bltu_pcsrc", PCSrcE, 0);
        BranchOpE = BR_BLT; #1;
        chk("blt_pcsrc", PCSrcE, 1);
        chk("blt_target", PCTargetE, 32'h1020);
        BranchOpE = BR_BGEU; #1;
        chk("bgeu_pcsrc", PCSrcE, 1);
        BranchOpE = 3'b010; #1;
        chk("br_unused_pcsrc", PCSrcE, 0);
        BranchOpE = BR_BLT; FlushE = 1; #1;
        chk("br_flush_pcsrc", PCSrcE, 0);
        nop();
        JalrE = 1; RD1E = 32'h2001; ImmExtE = 32'h10; #1;
        chk("jalr_target", PCTargetE, 32'h2010);
        chk("jalr_pcsrc", PCSrcE, 1);
        tick();

        // 3-4. Multiply / divide
        runMd("div_20_m3",   MD_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA);
        runMd("rem_20_m3",   MD_REM,    32'd20,       32'hFFFFFFFD, 32'd2);
        runMd("divu_by0",    MD_DIVU,   32'd7,        32'd0,        32'hFFFFFFFF);
        runMd("div_neg_by0", MD_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
        runMd("rem_neg_by0", MD_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
        runMd("rem_ovf",     MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0);
        runMd("div_ovf",     MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runMd("mulh_min",    MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        runMd("mulhu_max",   MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runMd("mulhsu_m1",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // 5. Flush during BUSY
        nop();
        MdOpE = 1; MdFunct3E = MD_DIV; RD1E = 100; RD2E = 7; RegWriteE = 1; RdE = 5'd4;
        #1;
        chk("flush_start_busy", BusyE, 1);
        repeat (10) tick();
        FlushE = 1; #1;
        chk("flush_cycle_busy", BusyE, 1);
        tick();
        nop();
        ALUControlE = ALU_ADD; RD1E = 40; RD2E = 2; RegWriteE = 1; RdE = 5'd6;
        #1;
        chk("flush_busy_drop", BusyE, 0);
        chk("flush_no_write", RegWriteM, 0);
        tick();
        chk("after_flush_add", ALUResultM, 42);
        chk("after_flush_rw", RegWriteM, 1);
        chk("after_flush_rd", RdM, 6);

        // 6. Reset in the middle of a multiply
        nop();
        ALUControlE = ALU_ADD; RD1E = 6; RD2E = 7; RegWriteE = 1; RdE = 5'd2; PCPlus4E = 32'h2004;
        tick();
        chk("pre_rst_add", ALUResultM, 13);
        MdOpE = 1; MdFunct3E = MD_MUL;
        repeat (5) tick();
        #2;
        resetn = 0;
        #1;
        chk("midrst_aluresult", ALUResultM, 0);
        chk("midrst_wdata", WriteDataM, 0);
        chk("midrst_pcplus4", PCPlus4M, RST_PC4);
        chk("midrst_busy", BusyE, 0);
        tick();
        resetn = 1;
        nop();
        runMd("mul_after_rst", MD_MUL, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
